// File: rtl/master_arb_pkg.sv
// Shared definitions for the AXI read/write channel arbiters: state encoding,
// master count, index type and grant decode helper.
package master_arb_pkg;

    localparam int NUM_MASTERS = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef logic [1:0] mst_idx_t;

    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input mst_idx_t idx);
        logic [NUM_MASTERS-1:0] oh;
        oh      = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-request round-robin picker: returns the first requester
// found searching ptr, ptr+1, ... (mod 4).
module rr_pick4 import master_arb_pkg::*; (
    input  logic [3:0] req,
    input  mst_idx_t   ptr,
    output logic       valid,
    output mst_idx_t   idx
);

    logic [3:0] rot_s;
    mst_idx_t   off_s;

    // Rotate so that bit 0 is the request at the pointer position.
    always_comb begin
        rot_s = req;
        case (ptr)
            2'd0:    rot_s = req;
            2'd1:    rot_s = {req[0],   req[3:1]};
            2'd2:    rot_s = {req[1:0], req[3:2]};
            2'd3:    rot_s = {req[2:0], req[3]};
            default: rot_s = req;
        endcase
    end

    // Fixed-priority encode of the rotated vector.
    always_comb begin
        valid = 1'b0;
        off_s = 2'd0;
        if (rot_s[0]) begin
            valid = 1'b1;
            off_s = 2'd0;
        end else if (rot_s[1]) begin
            valid = 1'b1;
            off_s = 2'd1;
        end else if (rot_s[2]) begin
            valid = 1'b1;
            off_s = 2'd2;
        end else if (rot_s[3]) begin
            valid = 1'b1;
            off_s = 2'd3;
        end else begin
            valid = 1'b0;
            off_s = 2'd0;
        end
    end

    assign idx = ptr + off_s;

endmodule

// File: rtl/master_arbiter_r.sv
// Round-robin read-channel arbiter for a 4-master / 1-slave AXI read path.
// Optional R-channel watchdog enabled by defining MASTER_ARBITER_R_TIMEOUT_EN.
module master_arbiter_r #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_CNT_W       = 11
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       m0_axi_arvalid,
    input  logic       m1_axi_arvalid,
    input  logic       m2_axi_arvalid,
    input  logic       m3_axi_arvalid,
    input  logic       s_arvalid,
    input  logic       m_arready,
    input  logic       s_rready,
    input  logic       m_rvalid,
    input  logic       m_rlast,
    output logic       m0_read_accept,
    output logic       m1_read_accept,
    output logic       m2_read_accept,
    output logic       m3_read_accept,
    output logic       rd_busy,
    output logic [1:0] rd_grant_idx
`ifdef MASTER_ARBITER_R_TIMEOUT_EN
    ,
    output logic       rd_timeout
`endif
);

    import master_arb_pkg::*;

    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    mst_idx_t               ptr_r;
    mst_idx_t               ptr_nxt_s;
    mst_idx_t               idx_r;
    mst_idx_t               idx_nxt_s;
    logic [NUM_MASTERS-1:0] accept_r;
    logic [NUM_MASTERS-1:0] accept_nxt_s;
    logic                   busy_r;
    logic                   busy_nxt_s;

    logic [3:0]             req_s;
    logic                   pick_valid_s;
    mst_idx_t               pick_idx_s;
    logic                   ar_hs_s;
    logic                   r_hs_s;
    logic                   r_last_hs_s;
    logic                   to_fire_s;

    assign req_s       = {m3_axi_arvalid, m2_axi_arvalid, m1_axi_arvalid, m0_axi_arvalid};
    assign ar_hs_s     = s_arvalid & m_arready;
    assign r_hs_s      = m_rvalid & s_rready;
    assign r_last_hs_s = r_hs_s & m_rlast;

    rr_pick4 u_pick (
        .req   (req_s),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

`ifdef MASTER_ARBITER_R_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt_r;
    logic                timeout_r;

    // The counter sits at zero outside DATA, so it is already clear on entry.
    assign to_fire_s = (state_r == ST_DATA) & ~r_hs_s &
                       (to_cnt_r == TO_CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: counts DATA cycles since the last R handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            to_cnt_r <= TO_CNT_W'(0);
        end else if (state_r != ST_DATA) begin
            to_cnt_r <= TO_CNT_W'(0);
        end else if (r_hs_s) begin
            to_cnt_r <= TO_CNT_W'(0);
        end else begin
            to_cnt_r <= to_cnt_r + TO_CNT_W'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            timeout_r <= 1'b0;
        end else if (to_fire_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign rd_timeout = timeout_r;
`else
    assign to_fire_s = 1'b0;
`endif

    // Next-state and next-output decode for the grant FSM.
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        idx_nxt_s    = idx_r;
        accept_nxt_s = accept_r;
        busy_nxt_s   = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s  = ST_ADDR;
                    idx_nxt_s    = pick_idx_s;
                    accept_nxt_s = idx_to_onehot(pick_idx_s);
                    busy_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    accept_nxt_s = 4'b0000;
                    busy_nxt_s   = 1'b0;
                end
            end
            ST_ADDR: begin
                // A master dropping ARVALID here simply keeps the grant parked.
                if (ar_hs_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (r_last_hs_s || to_fire_s) begin
                    state_nxt_s  = ST_IDLE;
                    accept_nxt_s = 4'b0000;
                    busy_nxt_s   = 1'b0;
                    ptr_nxt_s    = idx_r + 2'd1;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                accept_nxt_s = 4'b0000;
                busy_nxt_s   = 1'b0;
            end
        endcase
    end

    // FSM and registered output state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r  <= ST_IDLE;
            ptr_r    <= 2'd0;
            idx_r    <= 2'd0;
            accept_r <= 4'b0000;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            idx_r    <= idx_nxt_s;
            accept_r <= accept_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign m0_read_accept = accept_r[0];
    assign m1_read_accept = accept_r[1];
    assign m2_read_accept = accept_r[2];
    assign m3_read_accept = accept_r[3];
    assign rd_busy        = busy_r;
    assign rd_grant_idx   = idx_r;

endmodule

// File: tb/tb_master_arbiter_r.sv
// Self-checking bench for master_arbiter_r: directed scenarios plus random
// traffic, compared every cycle against a burst-level ownership model.
module tb_master_arbiter_r;

    localparam int TO_CYC = 16;

    logic       aclk;
    logic       areset;
    logic [3:0] arv;
    logic       s_arvalid;
    logic       m_arready;
    logic       s_rready;
    logic       m_rvalid;
    logic       m_rlast;
    logic       m0_read_accept;
    logic       m1_read_accept;
    logic       m2_read_accept;
    logic       m3_read_accept;
    logic       rd_busy;
    logic [1:0] rd_grant_idx;
`ifdef MASTER_ARBITER_R_TIMEOUT_EN
    logic       rd_timeout;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Model: which master owns the read channel and where the burst stands.
    int mdl_owner     = -1;
    int mdl_ptr       = 0;
    int mdl_last      = 0;
    bit mdl_addr_done = 1'b0;
    bit mdl_to        = 1'b0;
    int mdl_stall     = 0;

    master_arbiter_r #(.TIMEOUT_CYCLES(TO_CYC), .TO_CNT_W(5)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .m0_axi_arvalid (arv[0]),
        .m1_axi_arvalid (arv[1]),
        .m2_axi_arvalid (arv[2]),
        .m3_axi_arvalid (arv[3]),
        .s_arvalid      (s_arvalid),
        .m_arready      (m_arready),
        .s_rready       (s_rready),
        .m_rvalid       (m_rvalid),
        .m_rlast        (m_rlast),
        .m0_read_accept (m0_read_accept),
        .m1_read_accept (m1_read_accept),
        .m2_read_accept (m2_read_accept),
        .m3_read_accept (m3_read_accept),
        .rd_busy        (rd_busy),
        .rd_grant_idx   (rd_grant_idx)
`ifdef MASTER_ARBITER_R_TIMEOUT_EN
        ,
        .rd_timeout     (rd_timeout)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [3:0] acc_vec();
        return {m3_read_accept, m2_read_accept, m1_read_accept, m0_read_accept};
    endfunction

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_step();
        if (areset) begin
            mdl_owner = -1; mdl_ptr = 0; mdl_last = 0;
            mdl_addr_done = 1'b0; mdl_to = 1'b0; mdl_stall = 0;
        end else if (mdl_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (mdl_owner < 0 && arv[(mdl_ptr + k) % 4]) begin
                    mdl_owner     = (mdl_ptr + k) % 4;
                    mdl_last      = mdl_owner;
                    mdl_addr_done = 1'b0;
                end
            end
        end else if (!mdl_addr_done) begin
            if (s_arvalid && m_arready) begin
                mdl_addr_done = 1'b1;
                mdl_stall     = 0;
            end
        end else begin
            if (m_rvalid && s_rready) begin
                mdl_stall = 0;
                if (m_rlast) begin
                    mdl_ptr   = (mdl_owner + 1) % 4;
                    mdl_owner = -1;
                end
            end else begin
`ifdef MASTER_ARBITER_R_TIMEOUT_EN
                mdl_stall++;
                if (mdl_stall == TO_CYC) begin
                    mdl_to    = 1'b1;
                    mdl_ptr   = (mdl_owner + 1) % 4;
                    mdl_owner = -1;
                end
`endif
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] exp_acc;
        logic [3:0] one;
        one     = 4'b0001;
        exp_acc = (mdl_owner >= 0) ? (one << mdl_owner) : 4'b0000;
        n_assert++;
        assert (acc_vec() === exp_acc) else begin
            n_fail++;
            $error("FAIL accept: observed %b expected %b", acc_vec(), exp_acc);
        end
        n_assert++;
        assert (rd_busy === (mdl_owner >= 0)) else begin
            n_fail++;
            $error("FAIL busy: observed %b expected %b", rd_busy, (mdl_owner >= 0));
        end
        n_assert++;
        assert (rd_grant_idx === 2'(mdl_last)) else begin
            n_fail++;
            $error("FAIL grant_idx: observed %0d expected %0d", rd_grant_idx, mdl_last);
        end
`ifdef MASTER_ARBITER_R_TIMEOUT_EN
        n_assert++;
        assert (rd_timeout === mdl_to) else begin
            n_fail++;
            $error("FAIL timeout: observed %b expected %b", rd_timeout, mdl_to);
        end
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge aclk);
        #1;
        check_outputs();
    endtask

    // Directed check against a constant taken from the scenario description.
    task automatic expect_grant(input int exp_idx, input string tag);
        logic [3:0] one;
        one = 4'b0001;
        n_assert++;
        assert (rd_grant_idx === 2'(exp_idx) && acc_vec() === (one << exp_idx)) else begin
            n_fail++;
            $error("FAIL %s: observed idx %0d accept %b expected idx %0d", tag,
                   rd_grant_idx, acc_vec(), exp_idx);
        end
    endtask

    task automatic expect_released(input string tag);
        n_assert++;
        assert (acc_vec() === 4'b0000 && rd_busy === 1'b0) else begin
            n_fail++;
            $error("FAIL %s: observed accept %b busy %b expected 0000/0", tag, acc_vec(), rd_busy);
        end
    endtask

    task automatic do_burst(input int beats, input bit hold_req);
        int own;
        own = mdl_owner;
        s_arvalid = 1'b1; m_arready = 1'b1;
        tick();
        s_arvalid = 1'b0; m_arready = 1'b0;
        if (!hold_req && own >= 0) arv[own] = 1'b0;
        for (int b = 0; b < beats; b++) begin
            m_rvalid = 1'b1; s_rready = 1'b1; m_rlast = (b == beats - 1);
            tick();
        end
        m_rvalid = 1'b0; s_rready = 1'b0; m_rlast = 1'b0;
    endtask

    initial begin
        areset = 1'b1; arv = 4'b0000; s_arvalid = 1'b0; m_arready = 1'b0;
        s_rready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;

        // Reset and basic m2 burst.
        tick(); tick();
        expect_released("reset_state");
        areset = 1'b0;
        tick();
        arv = 4'b0100;
        tick();
        expect_grant(2, "m2_grant_latency");
        tick(); tick();
        expect_grant(2, "m2_held_in_addr");
        do_burst(4, 1'b0);
        expect_released("m2_release_after_rlast");
        // ptr is now 3: m0 and m3 both request, m3 must win.
        arv = 4'b1001;
        tick();
        expect_grant(3, "ptr3_picks_m3");
        do_burst(2, 1'b0);
        arv = 4'b0000;
        tick();

        // All four requesting continuously, single-beat bursts.
        arv = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            expect_grant(g % 4, "rr_order");
            do_burst(1, 1'b1);
            expect_released("rr_idle_gap");
        end
        arv = 4'b0000;
        tick();

        // RLAST offered without RREADY keeps the grant.
        arv = 4'b0100;
        tick();
        expect_grant(2, "stall_grant");
        s_arvalid = 1'b1; m_arready = 1'b1;
        tick();
        s_arvalid = 1'b0; m_arready = 1'b0; arv = 4'b0000;
        m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 1'b0;
        repeat (5) begin
            tick();
            expect_grant(2, "no_rready_hold");
        end
        s_rready = 1'b1;
        tick();
        expect_released("rready_release");
        m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b0;

        // Reset during beat 2 of an 8-beat burst.
        arv = 4'b0001;
        tick();
        expect_grant(0, "pre_reset_grant");
        s_arvalid = 1'b1; m_arready = 1'b1;
        tick();
        s_arvalid = 1'b0; m_arready = 1'b0; arv = 4'b0000;
        m_rvalid = 1'b1; s_rready = 1'b1; m_rlast = 1'b0;
        tick(); tick();
        areset = 1'b1;
        tick();
        expect_released("mid_burst_reset");
        areset = 1'b0; m_rvalid = 1'b0; s_rready = 1'b0;
        arv = 4'b1010;
        tick();
        expect_grant(1, "post_reset_ptr0");
        do_burst(3, 1'b0);

        // ptr = 2 with m0/m1/m3 requesting.
        arv = 4'b1011;
        tick();
        expect_grant(3, "ptr2_skips_to_m3");
        do_burst(2, 1'b0);
        tick();
        expect_grant(0, "wrap_to_m0");
        do_burst(1, 1'b0);
        arv = 4'b0000;
        tick(); tick();

`ifdef MASTER_ARBITER_R_TIMEOUT_EN
        // Watchdog: stall the R channel in DATA.
        arv = 4'b0010;
        tick();
        s_arvalid = 1'b1; m_arready = 1'b1;
        tick();
        s_arvalid = 1'b0; m_arready = 1'b0; arv = 4'b0000;
        repeat (TO_CYC - 1) tick();
        expect_grant(1, "before_timeout");
        tick();
        expect_released("timeout_release");
        n_assert++;
        assert (rd_timeout === 1'b1) else begin
            n_fail++;
            $error("FAIL timeout_set: observed %b expected 1", rd_timeout);
        end
        arv = 4'b0001;
        tick();
        do_burst(3, 1'b0);
        n_assert++;
        assert (rd_timeout === 1'b1) else begin
            n_fail++;
            $error("FAIL timeout_sticky: observed %b expected 1", rd_timeout);
        end
`endif

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            arv       = 4'($urandom);
            s_arvalid = 1'($urandom);
            m_arready = 1'($urandom);
            m_rvalid  = ($urandom_range(0, 3) != 0);
            s_rready  = 1'($urandom);
            m_rlast   = ($urandom_range(0, 2) == 0);
            areset    = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/master_arbiter_r.md
Name: master_arbiter_r

Overview:
- Read-channel arbiter for the 4-master, 1-slave AXI read path.
- Sits directly upstream of the read master mux and drives its one-hot m0..m3_read_accept select lines.
- Grants one master at a time in round-robin order.
- Holds the grant from AR issue until the final R beat (RLAST) of that burst has handshaken, then re-arbitrates.

Parameters:
- TIMEOUT_CYCLES, 1024, DATA-state cycles allowed with no R handshake before watchdog fires (optional feature only).
- TO_CNT_W, 11, width of the watchdog counter; must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- m0_axi_arvalid  in  1  master 0 read-address request.
- m1_axi_arvalid  in  1  master 1 read-address request.
- m2_axi_arvalid  in  1  master 2 read-address request.
- m3_axi_arvalid  in  1  master 3 read-address request.
- s_arvalid  in  1  muxed ARVALID toward slave.
- m_arready  in  1  slave ARREADY.
- s_rready  in  1  muxed RREADY toward slave.
- m_rvalid  in  1  slave RVALID.
- m_rlast  in  1  slave RLAST.
- m0_read_accept  out  1  one-hot grant to master 0 (registered).
- m1_read_accept  out  1  one-hot grant to master 1 (registered).
- m2_read_accept  out  1  one-hot grant to master 2 (registered).
- m3_read_accept  out  1  one-hot grant to master 3 (registered).
- rd_busy  out  1  high in ADDR or DATA state.
- rd_grant_idx  out  2  index of current or last granted master.
- rd_timeout  out  1  sticky watchdog flag; present only with the optional feature.

Behaviour:
- Clock and reset: one clock, aclk. Reset areset is synchronous, active-high.
- Reset values:
  - State IDLE.
  - All m*_read_accept = 0, rd_busy = 0.
  - rd_grant_idx = 0, RR pointer = 0.
  - rd_timeout = 0, watchdog counter = 0.
  - Reset asserted mid-burst aborts to IDLE on the next edge; no handshake tracking is retained.
- States: IDLE, ADDR, DATA. All outputs are registered; grant outputs are always one-hot or zero.
- IDLE:
  - If any m*_axi_arvalid is high, select the first requester searching ptr, ptr+1, ... (mod 4).
  - Next cycle: that accept is high, rd_grant_idx = winner, state ADDR.
  - No requesters: remain in IDLE with accepts 0.
- Latency: request seen in cycle N means accept is high in cycle N+1.
- ADDR:
  - Hold grant.
  - On s_arvalid & m_arready, go to DATA next cycle.
  - If the granted master drops arvalid (protocol violation), stay in ADDR with grant held.
- DATA:
  - Hold grant.
  - On m_rvalid & s_rready & m_rlast in the same cycle: accept goes low next cycle, state IDLE, ptr = (granted idx + 1) mod 4.
  - RVALID without RLAST, or RVALID without RREADY: remain in DATA.
- Re-arbitration gap: at least one IDLE cycle between bursts, so accept is low for one cycle minimum. A master cannot be granted back-to-back if any other master is requesting.
- Simultaneous requests: the RR pointer alone decides.
  - Example: ptr = 2 with m0/m1/m3 requesting grants m3.
- Single-beat burst (RLAST on first beat): handled identically to a multi-beat burst.
- Arithmetic: ptr and idx are 2-bit and wrap naturally (3 + 1 = 0).

Optional Feature:
- Macro: MASTER_ARBITER_R_TIMEOUT_EN.
- Enabled:
  - Counter clears on entering DATA and on every m_rvalid & s_rready.
  - Counter increments otherwise while in DATA.
  - On reaching TIMEOUT_CYCLES: set rd_timeout (sticky until areset), force state IDLE, deassert grant next cycle, advance ptr as for normal completion.
- Disabled:
  - No counter and no rd_timeout port.
  - DATA waits indefinitely for RLAST.

Decomposition:
- Shared package master_arb_pkg:
  - State encoding constants ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2.
  - NUM_MASTERS = 4.
  - 2-bit index typedef.
- Sub-module rr_pick4: combinational 4-request round-robin priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: valid, idx[1:0].
  - Reusable by the write-channel arbiter.

Test Plan:
- Reset, then m2 arvalid in cycle 3 -> m2_read_accept = 1 in cycle 4, rd_grant_idx = 2. m_arready in cycle 6 -> DATA. RLAST handshake after 4 beats -> accept = 0 the following cycle, ptr = 3.
- All four arvalid held high continuously, single-beat bursts -> grants in order m0, m1, m2, m3, m0; one idle cycle between each grant.
- DATA with m_rvalid = 1, m_rlast = 1, s_rready = 0 for 5 cycles -> grant held. Raise s_rready -> release on the next cycle.
- areset pulsed in DATA mid-burst (beat 2 of 8) -> next cycle all accepts = 0, rd_busy = 0, ptr = 0. A new m1 request is then granted normally.
- ptr = 2, requests m0 + m1 + m3 simultaneously -> m3 granted. After completion ptr = 0 -> m0 granted next.
- With MASTER_ARBITER_R_TIMEOUT_EN and TIMEOUT_CYCLES = 16: stall R for 16 cycles in DATA -> rd_timeout = 1 (sticky) and grant dropped. A subsequent normal burst completes with rd_timeout still 1.
